// File: rtl/sync_bus_rx.sv
// Receive-side synchroniser for an asynchronous WIDTH-bit bus: raw register, per-bit level
// sync, strobe-qualified capture and toggle req/ack handshake, with held valid and sticky overrun.

module sync_bus_rx_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst)
    if (rst) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};

  assign q = sr[STAGES-1];
endmodule

module sync_bus_rx #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] async_data,
  input  logic             async_stb,
  input  logic             async_req,
  input  logic             rd,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] sync_data,
  output logic             valid,
  output logic             ack,
  output logic             busy,
  output logic             overrun
);
  localparam int CW = $clog2(STAGES + 2);
  localparam logic [CW-1:0] HOLD_CNT = CW'(STAGES + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [WIDTH+1:0] chain_in, chain_out;
  logic [WIDTH-1:0] data_s;
  logic             stb_s, req_s;

  assign chain_in = {async_req, async_stb, async_data};

  // Every chain runs regardless of mode so a mode switch sees settled levels.
  for (genvar i = 0; i < WIDTH + 2; i++) begin : g_sync
    sync_bus_rx_chain #(.STAGES(STAGES)) u_chain (
      .clk (clk),
      .rst (rst),
      .d   (chain_in[i]),
      .q   (chain_out[i])
    );
  end

  assign data_s = chain_out[WIDTH-1:0];
  assign stb_s  = chain_out[WIDTH];
  assign req_s  = chain_out[WIDTH+1];

  logic [1:0]    mode_q;
  logic          stb_d, last_req;
  logic [CW-1:0] cnt;
  state_t        state, state_nx;
  logic          mode_chg, req_chg, cap2, cap3, cap, ovr_evt;

  assign mode_chg = (mode != mode_q);
  assign req_chg  = (req_s != last_req);
  assign cap2     = (mode == 2'd2) && !mode_chg && stb_s && !stb_d;
  assign cap      = cap2 || cap3;
  assign ovr_evt  = cap && valid && !rd;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    if (mode_chg) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    if (mode == 2'd3 && req_chg) state_nx = HOLD;
        HOLD:    if (cnt <= CW'(1)) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == HOLD);
    cap3 = (state == IDLE) && (mode == 2'd3) && !mode_chg && req_chg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= '0;
      stb_d     <= 1'b0;
      last_req  <= 1'b0;
      cnt       <= '0;
      sync_data <= '0;
      valid     <= 1'b0;
      ack       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mode_q <= mode;
      stb_d  <= stb_s;
      // A mode switch re-baselines the edge detectors so existing levels never capture.
      if (mode_chg) begin
        last_req <= req_s;
        cnt      <= '0;
      end else begin
        if (cap3) begin
          last_req <= req_s;
          ack      <= ~ack;
          cnt      <= HOLD_CNT;
        end else if (state == HOLD) begin
          cnt <= cnt - CW'(1);
        end
        if (mode == 2'd0)      sync_data <= async_data;
        else if (mode == 2'd1) sync_data <= data_s;
        else if (cap)          sync_data <= async_data;
      end

      if (mode_chg) valid <= 1'b0;
      else if (cap) valid <= 1'b1;
      else if (rd)  valid <= 1'b0;

      if (ovr_evt)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end
endmodule

// File: doc/sync_bus_rx.md
Name: sync_bus_rx

Overview:
Parametrised, multi-mode receive-side synchroniser for an asynchronous WIDTH-bit bus entering the clk domain. It is the next-generation replacement for the fixed 8-bit, four-way selectable synchroniser. It adds configurable stage depth, a toggle req/ack handshake mode, a held-valid/read interface and sticky overrun detection. It sits directly behind the pad inputs, ahead of any clk-domain consumer.

Parameters:
WIDTH, 8, data bus width (>=1)
STAGES, 2, flops per synchroniser chain (>=2)

Ports:
clk  in  1  destination-domain clock
rst  in  1  asynchronous, active-high reset
mode  in  2  0=raw register, 1=per-bit level sync, 2=strobe-qualified capture, 3=toggle handshake; synchronous to clk
async_data  in  WIDTH  asynchronous data bus
async_stb  in  1  asynchronous capture strobe (mode 2)
async_req  in  1  asynchronous request toggle (mode 3)
rd  in  1  consumer read; clears valid
ovr_clr  in  1  clears overrun
sync_data  out  WIDTH  data in clk domain
valid  out  1  captured word pending (modes 2/3)
ack  out  1  acknowledge toggle back to source (mode 3)
busy  out  1  mode 3 hold window active
overrun  out  1  sticky: pending word overwritten

Behaviour:
- Reset (async assert, sync-safe deassert not required here) clears every flop: sync_data=0, valid=0, ack=0, busy=0, overrun=0; all chains 0; FSM=IDLE.
- Chains always run in every mode: stb_s = async_stb through STAGES flops; req_s = async_req through STAGES flops; data_s = each async_data bit through STAGES flops.
- Mode 0: sync_data <= async_data every edge (1 flop, no sync); valid/ack/busy unchanged-at-0 after mode entry.
- Mode 1: sync_data <= data_s; the bit at sync_data appears on edge STAGES+1 after first sample edge; valid stays 0.
- Mode 2: stb_d = stb_s delayed 1. Capture when stb_s=1 and stb_d=0: sync_data <= async_data (raw; source contract: data stable while stb high, stb high >= STAGES+1 clk periods, low >= STAGES+1 periods). The edge first sampling stb=1 is edge 1; capture is on edge STAGES+1.
- Mode 3 FSM, states IDLE, HOLD:
  IDLE: if req_s != last_req -> sync_data <= async_data, last_req <= req_s, ack toggles, hold counter <= STAGES+1, busy=1, go to HOLD.
  HOLD: counter decrements each edge; at 0, busy=0 and return to IDLE.
  A req change arriving during HOLD is not lost: the comparison is level-based and is serviced on the first IDLE cycle.
- valid/overrun (modes 2/3): every capture sets valid=1.
  - Capture while valid=1 and rd=0 -> overrun=1 (sticky), data overwritten.
  - rd and capture in the same cycle -> valid stays 1, no overrun.
  - rd with valid=0 is ignored; rd alone clears valid next edge.
  - ovr_clr clears overrun; a simultaneous overrun event wins (overrun=1).
- Mode change (registered mode differs from mode): valid<=0, FSM<=IDLE, busy<=0, counter<=0, last_req<=req_s, stb_d<=stb_s. Result: no spurious capture from levels already present. sync_data, ack and overrun are held.
- Widths: counter ceil(log2(STAGES+2)) bits; no arithmetic on data.

Test Plan:
- Reset: drive async_data=8'hFF, rst=1 mid-cycle -> all outputs 0 immediately, without waiting for a clk edge; release, mode=0 -> sync_data=8'hFF on next edge.
- Mode 1, STAGES=2: async_data 8'h00->8'h55 between edges -> sync_data=8'h55 on 3rd edge, unchanged on edges 1-2; valid stays 0.
- Mode 2: data=8'hA5, stb high 4 cycles -> sync_data=8'hA5, valid=1 on edge 3; second stb with data=8'h3C and no rd -> overrun=1, sync_data=8'h3C; ovr_clr -> overrun=0.
- Mode 3: toggle req with data=8'h5A -> capture, ack toggles 0->1, busy=1 for 3 cycles. Re-toggle req during busy with data=8'hC3 -> second capture on first IDLE cycle, ack returns to 0.
- rd coincident with capture (mode 2) -> valid remains 1, overrun remains 0.
- Switch mode 1->2 while async_stb already high -> no capture, valid=0; next fresh stb rising edge captures normally.
